// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and helpers for the load/store unit.
//   - size_e   : access size encoding as it appears on req_size
//   - state_e  : control FSM states of load_store_unit
//   - misaligned()  : alignment rule for a given size and byte offset
//   - lane_merge()  : insert a byte/halfword into an existing word (RMW store)
//   - load_extend() : pick the addressed lane of a word and sign/zero extend
//   All lane arithmetic is little-endian: byte lane = addr[1:0],
//   halfword lane = addr[1].
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_e;

    localparam int WORD_BITS = 32;

    // Halfwords need an even address, words a multiple of four.
    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        logic result;
        case (size)
            SZ_HALF: result = off[0];
            SZ_WORD: result = (off != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // Replace the addressed lane of old_word with the low bits of data.
    // Word-sized merges simply return data.
    function automatic logic [WORD_BITS-1:0] lane_merge(
        input logic [WORD_BITS-1:0] old_word,
        input logic [WORD_BITS-1:0] data,
        input size_e                size,
        input logic [1:0]           off
    );
        logic [WORD_BITS-1:0] result;
        result = old_word;
        case (size)
            SZ_BYTE: result[{off, 3'b000} +: 8]       = data[7:0];
            SZ_HALF: result[{off[1], 4'b0000} +: 16]  = data[15:0];
            default: result                           = data;
        endcase
        return result;
    endfunction

    // Extract the addressed lane and extend it to a full word. The sign
    // bit is the top bit of the lane unless is_unsigned is set; word loads
    // return the word untouched.
    function automatic logic [WORD_BITS-1:0] load_extend(
        input logic [WORD_BITS-1:0] word,
        input size_e                size,
        input logic [1:0]           off,
        input logic                 is_unsigned
    );
        logic [7:0]           lane_b;
        logic [15:0]          lane_h;
        logic                 sign_b;
        logic                 sign_h;
        logic [WORD_BITS-1:0] result;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = word[{off[1], 4'b0000} +: 16];
        sign_b = lane_b[7] & ~is_unsigned;
        sign_h = lane_h[15] & ~is_unsigned;
        case (size)
            SZ_BYTE: result = {{24{sign_b}}, lane_b};
            SZ_HALF: result = {{16{sign_h}}, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage : lsu_pkg

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for the load/store unit.
//   Ports:
//     rd_word     in  32  word currently read from data memory
//     wdata       in  32  right-aligned store data
//     size        in  2   access size (size_e)
//     off         in  2   byte offset within the word (addr[1:0])
//     is_unsigned in  1   zero-extend loads when high
//     load_data   out 32  extracted and extended load result
//     merged_word out 32  rd_word with the addressed lane replaced by wdata
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    assign load_data   = load_extend(rd_word, size, off, is_unsigned);
    assign merged_word = lane_merge(rd_word, wdata, size, off);

endmodule : lsu_align

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the word-addressed data memory. Takes one load/store
//   request at a time over a valid/ready handshake, performs byte/halfword/
//   word accesses (sub-word stores via read-modify-write) and returns a
//   one-cycle response pulse with extended load data and a fault flag.
//
//   Parameters:
//     DEPTH  number of 32-bit words in the attached memory
//     AW     width of the CPU byte address
//   Ports:
//     clk, rst       clock (rising edge), asynchronous active-high reset
//     req_valid/req_ready          request handshake (ready only in IDLE)
//     req_we, req_size, req_unsigned, req_addr, req_wdata  request fields
//     resp_valid     one-cycle completion pulse
//     resp_rdata     extended load data (0 for stores and faults)
//     resp_fault     fault flag, qualified by resp_valid
//     mem_a, mem_we, mem_wd        memory word index, write enable, data
//     mem_rd         combinational memory read data
//
//   Latency from accept edge to resp_valid: fault 1, load 2, word store 2,
//   sub-word store 3 cycles.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_fault,
    output logic [31:0]   mem_a,
    output logic          mem_we,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    // Control state and captured request
    state_e        state_reg;
    logic          we_reg;
    size_e         size_reg;
    logic          unsigned_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0]   wdata_reg;

    // Registered outputs
    logic          req_ready_reg;
    logic          resp_valid_reg;
    logic [31:0]   resp_rdata_reg;
    logic          resp_fault_reg;
    logic          mem_we_reg;
    logic [31:0]   mem_wd_reg;

    // Request decode, only meaningful in IDLE at the accept edge
    logic          accept;
    size_e         req_size_e;
    logic [AW-1:0] req_word_idx;
    logic          req_fault;
    logic          req_word_store;

    // Lane logic results on the captured request and live memory data
    logic [31:0]   load_data;
    logic [31:0]   merged_word;

    assign accept         = req_valid && req_ready_reg;
    assign req_size_e     = size_e'(req_size);
    assign req_word_idx   = req_addr >> 2;
    assign req_fault      = (req_size_e == SZ_ILLEGAL)
                         || misaligned(req_size_e, req_addr[1:0])
                         || (req_word_idx >= AW'(DEPTH));
    assign req_word_store = req_we && (req_size_e == SZ_WORD);

    lsu_align u_align (
        .rd_word     (mem_rd),
        .wdata       (wdata_reg),
        .size        (size_reg),
        .off         (addr_reg[1:0]),
        .is_unsigned (unsigned_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            size_reg       <= SZ_BYTE;
            unsigned_reg   <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_fault_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_wd_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg         <= req_we;
                        size_reg       <= req_size_e;
                        unsigned_reg   <= req_unsigned;
                        addr_reg       <= req_addr;
                        wdata_reg      <= req_wdata;
                        req_ready_reg  <= 1'b0;
                        resp_rdata_reg <= '0;
                        mem_wd_reg     <= req_wdata;
                        if (req_fault) begin
                            // Faults skip memory entirely and respond next cycle
                            resp_fault_reg <= 1'b1;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= RESP;
                        end else begin
                            resp_fault_reg <= 1'b0;
                            // A word store writes during ACCESS, so raise the
                            // enable together with the captured address.
                            mem_we_reg     <= req_word_store;
                            state_reg      <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (!we_reg) begin
                        resp_rdata_reg <= load_data;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else if (size_reg == SZ_WORD) begin
                        // The word write lands on this edge
                        mem_we_reg     <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        // Sub-word store: old word is on mem_rd now, write
                        // the merged result in the next cycle.
                        mem_wd_reg     <= merged_word;
                        mem_we_reg     <= 1'b1;
                        state_reg      <= WRITE;
                    end
                end

                WRITE: begin
                    mem_we_reg     <= 1'b0;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= RESP;
                end

                RESP: begin
                    resp_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    state_reg      <= IDLE;
                end

                default: begin
                    state_reg     <= IDLE;
                    mem_we_reg    <= 1'b0;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_fault = resp_fault_reg;
    assign mem_a      = 32'(addr_reg >> 2);
    assign mem_we     = mem_we_reg;
    assign mem_wd     = mem_wd_reg;

endmodule : load_store_unit

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts one load/store request at a time from the CPU datapath over a valid/ready handshake.
- Drives the word-addressed data memory: combinational read data, write on the rising clock edge when write enable is high.
- Supports byte, halfword and word accesses. Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Misaligned and out-of-range accesses raise a fault.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached data memory.
- AW, 32, width of the CPU byte address.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load when 1, else sign-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and faults)
- resp_fault  out  1  qualified by resp_valid
- mem_a  out  32  word index into memory (req_addr >> 2)
- mem_we  out  1  memory write enable
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data (combinational)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port rst.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_a=0, mem_wd=0. All request registers are cleared.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. All req_* fields are captured into registers at that edge. The memory-side ports are driven only from the captured registers, never directly from req_* inputs.
- Fault check, evaluated at accept:
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0
  - illegal size: req_size=11
  - out of range: (addr>>2) >= DEPTH
  - On a fault the unit goes directly to RESP with fault=1. mem_we is never asserted for a faulting request.
- States:
  - IDLE: req_ready=1. On accept go to FAULT-RESP if faulting, else ACCESS.
  - ACCESS: mem_a=captured word index.
    - Load: latch the extracted and extended lane of mem_rd, then go to RESP.
    - Word store: mem_we=1, mem_wd=wdata, then go to RESP.
    - Sub-word store: mem_we=0; latch the merged word (old mem_rd with the target lane replaced), then go to WRITE.
  - WRITE: mem_we=1, mem_wd=merged word, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in this state.
- Latency, accept edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - fault: 1 cycle
- Lanes: little-endian.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Store data source: wdata[7:0] for byte stores, wdata[15:0] for halfword stores.
- Extension: sign from bit 7 (byte) or bit 15 (halfword) unless unsigned. Word loads ignore req_unsigned.
- mem_we is high only in ACCESS (word store) or WRITE; exactly one write per successful store.
- req_valid held high during busy states is ignored, not queued.
- rst asserted in any state: immediate return to IDLE with mem_we=0 asynchronously. No partial RMW write lands, and no response is issued for the aborted request.

Decomposition:
- Shared package lsu_pkg holds:
  - size_e enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL
  - state_e enum: IDLE, ACCESS, WRITE, RESP
  - function lane_merge(old, data, size, off)
  - function load_extend(word, size, off, unsigned)
- One combinational sub-module, lsu_align, wraps the two functions: byte-lane extraction/extension and store merge. The FSM stays in the top module.

Test Plan:
- Memory preloaded mem[30]=0x00000020: load word addr 0x78 -> resp_valid 2 cycles after accept, rdata=0x00000020, fault=0, mem_we never high.
- mem[4]=0x80FF7F01:
  - load byte signed addr 0x13 -> 0xFFFFFF80
  - load byte unsigned addr 0x13 -> 0x00000080
  - load half signed addr 0x12 -> 0xFFFF80FF
- mem[4]=0x11223344: store byte 0xAA at addr 0x11 -> one mem_we pulse in WRITE with mem_wd=0x1122AA44 at mem_a=4. resp 3 cycles after accept; reload word gives 0x1122AA44.
- Faults, each giving resp_valid 1 cycle after accept, fault=1, rdata=0, mem_we never asserted:
  - store word addr 0x2 (misaligned)
  - load half addr 0x7 (misaligned)
  - load word addr 0x1000 (word index 1024 with DEPTH=1024, out of range)
- Back-to-back: req_valid held high with two queued requests -> second accepted only after resp_valid, and req_ready low for the entire busy window.
- Sub-word store to 0x10, rst pulsed during WRITE -> mem_we drops immediately, mem[4] unchanged, no resp_valid, req_ready=1 after reset.
